// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types and constants for the MEM-stage load/store unit
package mem_lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_WR   = 3'd3,
      S_B    = 3'd4,
      S_DONE = 3'd5
   } lsu_state_t;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - access legality check, store lane placement and load extraction
module mem_lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  off,
   input  logic        is_load,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic        fault,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] ldata
);

   logic        legal;
   logic        misaligned;
   logic [31:0] sh;

   always_comb begin
      legal = 1'b0;
      if (is_load)
         legal = (func3 == LB) || (func3 == LH) || (func3 == LW) ||
                 (func3 == LBU) || (func3 == LHU);
      else
         legal = (func3 == SB) || (func3 == SH) || (func3 == SW);
   end

   assign misaligned = ((func3[1:0] == 2'b01) && off[0]) ||
                       ((func3[1:0] == 2'b10) && (off != 2'b00));
   assign fault = ~legal | misaligned;

   assign wdata = rs2 << {off, 3'b000};

   always_comb begin
      wstrb = 4'b1111;
      case (func3[1:0])
         2'b00:   wstrb = 4'b0001 << off;
         2'b01:   wstrb = 4'b0011 << off;
         default: wstrb = 4'b1111;
      endcase
   end

   assign sh = rdata >> {off, 3'b000};

   always_comb begin
      ldata = sh;
      case (func3)
         LB:      ldata = {{24{sh[7]}}, sh[7:0]};
         LBU:     ldata = {24'd0, sh[7:0]};
         LH:      ldata = {{16{sh[15]}}, sh[15:0]};
         LHU:     ldata = {16'd0, sh[15:0]};
         default: ldata = sh;
      endcase
   end

endmodule

// File: rtl/mem_lsu_axi.sv
// rtl/mem_lsu_axi.sv - MEM-stage load/store unit issuing one AXI4-Lite transaction per access
module mem_lsu_axi
   import mem_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MEM_i_mem_to_reg,
   input  logic              MEM_i_write_mem,
   input  logic [2:0]        MEM_i_func3,
   input  logic [31:0]       MEM_i_ALU_ALUout,
   input  logic [31:0]       MEM_i_rs2_data,
   input  logic              FORWARD_stallME,
   output logic              MEM_rvalid,
   output logic              MEM_wready,
   output logic [31:0]       MEM_o_rdata,
   output logic              MEM_o_fault,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready
);

   lsu_state_t  state, state_next;
   logic        is_load, is_store;
   logic [31:0] addr_q, rs2_q;
   logic [2:0]  func3_q;
   logic        aw_done, w_done;
   logic [31:0] rdata_q;
   logic        fault_q;
   logic        req_fault;
   logic [31:0] ldata;
   logic [2:0]  sel_func3;
   logic [1:0]  sel_off;

   // a load wins when both flags are set
   assign is_load  = MEM_i_mem_to_reg;
   assign is_store = MEM_i_write_mem & ~MEM_i_mem_to_reg;

   // live request is checked in IDLE; the latched copy drives the bus afterwards
   assign sel_func3 = (state == S_IDLE) ? MEM_i_func3 : func3_q;
   assign sel_off   = (state == S_IDLE) ? MEM_i_ALU_ALUout[1:0] : addr_q[1:0];

   mem_lsu_align u_align (
      .func3   (sel_func3),
      .off     (sel_off),
      .is_load (is_load),
      .rs2     (rs2_q),
      .rdata   (rdata),
      .fault   (req_fault),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .ldata   (ldata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      arvalid    = 1'b0;
      rready     = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (is_load || is_store)
               state_next = req_fault ? S_DONE : (is_load ? S_AR : S_WR);
         end
         S_AR: begin
            arvalid = 1'b1;
            if (arready) state_next = S_R;
         end
         S_R: begin
            rready = 1'b1;
            if (rvalid) state_next = S_DONE;
         end
         S_WR: begin
            awvalid = ~aw_done;
            wvalid  = ~w_done;
            if ((aw_done || awready) && (w_done || wready)) state_next = S_B;
         end
         S_B: begin
            bready = 1'b1;
            if (bvalid) state_next = S_DONE;
         end
         S_DONE: begin
            if (!FORWARD_stallME) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         rs2_q   <= '0;
         func3_q <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_load || is_store) begin
                  addr_q  <= MEM_i_ALU_ALUout;
                  rs2_q   <= MEM_i_rs2_data;
                  func3_q <= MEM_i_func3;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  fault_q <= req_fault;
               end
            end
            S_R: begin
               if (rvalid) begin
                  rdata_q <= ldata;
                  fault_q <= (rresp != OKAY);
               end
            end
            S_WR: begin
               if (awvalid && awready) aw_done <= 1'b1;
               if (wvalid && wready)   w_done  <= 1'b1;
            end
            S_B: begin
               if (bvalid) fault_q <= (bresp != OKAY);
            end
            S_DONE: begin
               if (!FORWARD_stallME) fault_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign araddr      = addr_q[ADDR_W-1:0];
   assign awaddr      = addr_q[ADDR_W-1:0];
   assign MEM_o_rdata = rdata_q;
   assign MEM_o_fault = fault_q;
   assign MEM_rvalid  = ~is_load  | (state == S_DONE);
   assign MEM_wready  = ~is_store | (state == S_DONE);

endmodule

// File: tb/tb_mem_lsu_axi.sv
// tb/tb_mem_lsu_axi.sv - directed and randomized self-checking bench for mem_lsu_axi
module tb_mem_lsu_axi;

   logic        clk, rst_n;
   logic        mem_to_reg, write_mem, stall;
   logic [2:0]  func3;
   logic [31:0] alu_out, rs2_data;
   logic        MEM_rvalid, MEM_wready, MEM_o_fault;
   logic [31:0] MEM_o_rdata;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   int checks = 0;
   int errors = 0;

   mem_lsu_axi dut (
      .clk(clk), .rst_n(rst_n),
      .MEM_i_mem_to_reg(mem_to_reg), .MEM_i_write_mem(write_mem),
      .MEM_i_func3(func3), .MEM_i_ALU_ALUout(alu_out), .MEM_i_rs2_data(rs2_data),
      .FORWARD_stallME(stall),
      .MEM_rvalid(MEM_rvalid), .MEM_wready(MEM_wready),
      .MEM_o_rdata(MEM_o_rdata), .MEM_o_fault(MEM_o_fault),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference: behaviour from the access rules, expressed in bytes and arithmetic
   function automatic void model(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] rs2, input logic [31:0] rd,
                                 output logic flt, output logic [31:0] ldv,
                                 output logic [31:0] wdv, output logic [3:0] ws);
      int off, bytes;
      bit legal;
      logic [31:0] sh;
      off   = int'(addr % 4);
      bytes = 1 << f3[1:0];
      if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      flt = !legal || ((addr % bytes) != 0);
      sh  = rd >> (8 * off);
      if (bytes == 1) begin
         ldv = sh & 32'hFF;
         if (!f3[2] && ldv >= 32'd128) ldv = ldv - 32'd256;
      end else if (bytes == 2) begin
         ldv = sh & 32'hFFFF;
         if (!f3[2] && ldv >= 32'd32768) ldv = ldv - 32'd65536;
      end else begin
         ldv = sh;
      end
      wdv = rs2 << (8 * off);
      ws  = 4'(((32'd1 << bytes) - 32'd1) << off);
   endfunction

   task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rd,
                         input logic [1:0] resp, input int ar_w, input int r_w,
                         input int aw_w, input int w_w, input int b_w, input int hold);
      logic is_ld, is_st, flt, flt_exp;
      logic [31:0] ld_exp, wd_exp, rd_cap;
      logic [3:0]  ws_exp;
      int lat_exp, done_c, ar_n, r_n, aw_n, w_n, b_n;
      bit aw_hs, w_hs, seen_valid;
      is_ld = ld;
      is_st = st & ~ld;
      model(is_ld, f3, addr, rs2, rd, flt, ld_exp, wd_exp, ws_exp);
      @(negedge clk);
      mem_to_reg = ld; write_mem = st; func3 = f3; alu_out = addr; rs2_data = rs2; stall = 1'b1;
      #1;
      if (!is_ld && !is_st) begin
         @(negedge clk);
         chk("idle_levels", {30'd0, MEM_rvalid, MEM_wready}, 32'd3);
         chk("idle_no_bus", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
         return;
      end
      chk("pending_levels", {30'd0, MEM_rvalid, MEM_wready}, {30'd0, ~is_ld, ~is_st});
      if (flt)        lat_exp = 1;
      else if (is_ld) lat_exp = 3 + ar_w + r_w;
      else            lat_exp = 3 + ((aw_w > w_w) ? aw_w : w_w) + b_w;
      flt_exp = flt || (resp != 2'b00);
      done_c = 0; ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0;
      aw_hs = 0; w_hs = 0; seen_valid = 0;
      for (int c = 1; c <= 50 && done_c == 0; c++) begin
         @(negedge clk);
         arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
         rdata = $urandom; rresp = 2'($urandom); bresp = 2'($urandom);
         if (arvalid || awvalid || wvalid) seen_valid = 1;
         if (is_ld ? MEM_rvalid : MEM_wready) begin
            done_c = c;
         end else begin
            if (arvalid) begin
               chk("araddr", araddr, addr);
               ar_n++;
               if (ar_n == ar_w + 1) arready = 1;
            end
            if (rready) begin
               r_n++;
               if (r_n == r_w + 1) begin rvalid = 1; rdata = rd; rresp = resp; end
            end
            if (awvalid) begin
               chk("awaddr", awaddr, addr);
               chk("awvalid_after_hs", {31'd0, aw_hs}, 32'd0);
               aw_n++;
               if (aw_n == aw_w + 1) begin awready = 1; aw_hs = 1; end
            end
            if (wvalid) begin
               chk("wdata", wdata, wd_exp);
               chk("wstrb", {28'd0, wstrb}, {28'd0, ws_exp});
               chk("wvalid_after_hs", {31'd0, w_hs}, 32'd0);
               w_n++;
               if (w_n == w_w + 1) begin wready = 1; w_hs = 1; end
            end
            if (bready) begin
               b_n++;
               if (b_n == 1) chk("b_after_both", {30'd0, aw_hs, w_hs}, 32'd3);
               if (b_n == b_w + 1) begin bvalid = 1; bresp = resp; end
            end
         end
      end
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      chk("latency", done_c, lat_exp);
      chk("fault", {31'd0, MEM_o_fault}, {31'd0, flt_exp});
      chk("done_levels", {30'd0, MEM_rvalid, MEM_wready}, 32'd3);
      if (flt) chk("no_bus_on_fault", {31'd0, seen_valid}, 32'd0);
      if (is_ld && !flt) chk("load_data", MEM_o_rdata, ld_exp);
      rd_cap = MEM_o_rdata;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_data", MEM_o_rdata, rd_cap);
         chk("hold_fault", {30'd0, MEM_o_fault, MEM_rvalid & MEM_wready}, {30'd0, flt_exp, 1'b1});
      end
      @(negedge clk);
      stall = 0; mem_to_reg = 0; write_mem = 0;
      @(negedge clk);
      stall = 1;
      chk("fault_cleared", {31'd0, MEM_o_fault}, 32'd0);
   endtask

   initial begin
      logic got;
      rst_n = 0; mem_to_reg = 0; write_mem = 0; func3 = 0; alu_out = 0; rs2_data = 0; stall = 1;
      arready = 0; rdata = 0; rresp = 0; rvalid = 0; awready = 0; wready = 0; bresp = 0; bvalid = 0;
      repeat (2) @(negedge clk);
      chk("reset_bus", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
      chk("reset_rdata", MEM_o_rdata, 32'd0);
      chk("reset_levels", {29'd0, MEM_o_fault, MEM_rvalid, MEM_wready}, 32'd3);
      rst_n = 1;

      access(1, 0, 3'b010, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0);
      access(1, 0, 3'b000, 32'h8000_0003, 32'd0, 32'h8012_3456, 2'b00, 0, 0, 0, 0, 0, 0);
      access(1, 0, 3'b100, 32'h8000_0003, 32'd0, 32'h8012_3456, 2'b00, 1, 1, 0, 0, 0, 1);
      access(0, 1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'd0, 2'b00, 0, 0, 2, 0, 0, 0);
      access(0, 1, 3'b010, 32'h8000_0002, 32'h1111_2222, 32'd0, 2'b00, 0, 0, 0, 0, 0, 0);
      access(1, 0, 3'b010, 32'h8000_0008, 32'd0, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 0, 0, 5);
      access(1, 1, 3'b101, 32'h8000_0006, 32'hFFFF_FFFF, 32'hBEEF_0000, 2'b00, 0, 2, 0, 0, 0, 0);

      // asynchronous reset while the read data phase is open
      @(negedge clk);
      mem_to_reg = 1; write_mem = 0; func3 = 3'b010; alu_out = 32'h8000_0010; stall = 1;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         arready = arvalid;
         if (rready) got = 1;
      end
      chk("reach_r", {31'd0, got}, 32'd1);
      arready = 0;
      rst_n = 0;
      #1;
      chk("async_rst_bus", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
      chk("async_rst_out", {30'd0, MEM_o_fault, MEM_rvalid}, 32'd0);
      mem_to_reg = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("post_rst_idle", {27'd0, arvalid, rready, MEM_rvalid, MEM_wready, MEM_o_fault}, 32'd6);

      for (int i = 0; i < 40; i++) begin
         int sel;
         logic [1:0] rsp;
         sel = int'($urandom_range(0, 3));
         rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         access(sel[0], sel[1], 3'($urandom_range(0, 7)),
                32'h8000_0000 | ($urandom & 32'hFFF), $urandom, $urandom, rsp,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
